// File: rtl/number_sequencer_if.sv
// Bundle between the sync generator, the digit-box sequencer and the number renderer.
// master = the sequencer side; slave = the sync generator / renderer side.
interface number_sequencer_if;
  logic [9:0] x_px;
  logic [9:0] y_px;
  logic       enable;
  logic [9:0] x_numbers;
  logic [9:0] y_numbers;
  logic [2:0] number;
  logic       frame_tick;

  modport master (
    input  x_px, y_px, enable,
    output x_numbers, y_numbers, number, frame_tick
  );

  modport slave (
    output x_px, y_px, enable,
    input  x_numbers, y_numbers, number, frame_tick
  );
endinterface

// File: rtl/number_sequencer.sv
// Once per frame (at blanking start) steps the digit box one STEP, bouncing off the
// screen edges, and advances the displayed digit every FRAMES_PER_COUNT frames.
module number_sequencer #(
  parameter int unsigned H_ACTIVE         = 640,
  parameter int unsigned V_ACTIVE         = 480,
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned HEIGHT           = 19,
  parameter int unsigned STEP             = 1,
  parameter int unsigned FRAMES_PER_COUNT = 60,
  parameter int unsigned X_INIT           = 312,
  parameter int unsigned Y_INIT           = 230
) (
  input  logic                clk,
  input  logic                reset,
  number_sequencer_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE_X, S_MOVE_Y, S_COUNT} state_t;

  localparam logic [10:0] L_H     = 11'(H_ACTIVE);
  localparam logic [10:0] L_V     = 11'(V_ACTIVE);
  localparam logic [10:0] L_W     = 11'(WIDTH);
  localparam logic [10:0] L_HT    = 11'(HEIGHT);
  localparam logic [10:0] L_STEP  = 11'(STEP);
  localparam logic [9:0]  L_XMAX  = 10'(H_ACTIVE - WIDTH);
  localparam logic [9:0]  L_YMAX  = 10'(V_ACTIVE - HEIGHT);
  localparam logic [9:0]  L_FLAST = 10'(FRAMES_PER_COUNT - 1);

  state_t      r_state, w_state_next;
  logic [9:0]  r_x, r_y, w_x_next, w_y_next;
  logic        r_dir_x, r_dir_y, w_dir_x_next, w_dir_y_next;
  logic [9:0]  r_fcnt, w_fcnt_next;
  logic [2:0]  r_num, w_num_next;
  logic        r_tick, w_tick_next;
  logic        r_sof_q;
  logic        w_sof, w_event;
  logic [10:0] w_x_ext, w_y_ext;

  assign w_sof   = (bus.x_px == '0) && (bus.y_px == L_V[9:0]);
  assign w_event = w_sof && !r_sof_q;
  assign w_x_ext = {1'b0, r_x};
  assign w_y_ext = {1'b0, r_y};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_dir_x_next = r_dir_x;
    w_dir_y_next = r_dir_y;
    w_fcnt_next  = r_fcnt;
    w_num_next   = r_num;
    w_tick_next  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Events seen while disabled are dropped rather than queued.
        if (w_event && bus.enable) begin
          w_state_next = S_MOVE_X;
          w_tick_next  = 1'b1;
        end
      end
      S_MOVE_X: begin
        w_state_next = S_MOVE_Y;
        if (!r_dir_x) begin
          if (w_x_ext + L_W + L_STEP > L_H) begin
            w_x_next     = L_XMAX;
            w_dir_x_next = 1'b1;
          end else begin
            w_x_next = 10'(w_x_ext + L_STEP);
          end
        end else begin
          if (w_x_ext < L_STEP) begin
            w_x_next     = '0;
            w_dir_x_next = 1'b0;
          end else begin
            w_x_next = 10'(w_x_ext - L_STEP);
          end
        end
      end
      S_MOVE_Y: begin
        w_state_next = S_COUNT;
        if (!r_dir_y) begin
          if (w_y_ext + L_HT + L_STEP > L_V) begin
            w_y_next     = L_YMAX;
            w_dir_y_next = 1'b1;
          end else begin
            w_y_next = 10'(w_y_ext + L_STEP);
          end
        end else begin
          if (w_y_ext < L_STEP) begin
            w_y_next     = '0;
            w_dir_y_next = 1'b0;
          end else begin
            w_y_next = 10'(w_y_ext - L_STEP);
          end
        end
      end
      S_COUNT: begin
        w_state_next = S_IDLE;
        if (r_fcnt == L_FLAST) begin
          w_fcnt_next = '0;
          w_num_next  = r_num + 3'd1;
        end else begin
          w_fcnt_next = r_fcnt + 10'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x     <= 10'(X_INIT);
      r_y     <= 10'(Y_INIT);
      r_dir_x <= 1'b0;
      r_dir_y <= 1'b0;
      r_fcnt  <= '0;
      r_num   <= '0;
      r_tick  <= 1'b0;
      r_sof_q <= 1'b0;
    end else begin
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_dir_x <= w_dir_x_next;
      r_dir_y <= w_dir_y_next;
      r_fcnt  <= w_fcnt_next;
      r_num   <= w_num_next;
      r_tick  <= w_tick_next;
      r_sof_q <= w_sof;
    end
  end

  assign bus.x_numbers  = r_x;
  assign bus.y_numbers  = r_y;
  assign bus.number     = r_num;
  assign bus.frame_tick = r_tick;

endmodule

// File: doc/number_sequencer.md
# number_sequencer

Frame-synchronous controller that drives the position and digit-select inputs of the number renderer (`x_numbers`, `y_numbers`, `number`). It watches the scan position, and once per frame, in vertical blanking, it moves the digit box one step and bounces it off the screen edges. It also advances the displayed digit every `FRAMES_PER_COUNT` frames. It sits between the VGA sync generator and the number graphics block, and is the only writer of those three signals.

## Interface

- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `WIDTH`, 16: digit box width in pixels.
- `HEIGHT`, 19: digit box height in pixels.
- `STEP`, 1: pixels moved per frame on each axis (1..15).
- `FRAMES_PER_COUNT`, 60: frames between digit increments (1..1023).
- `X_INIT`, 312: reset x position (≤ H_ACTIVE−WIDTH).
- `Y_INIT`, 230: reset y position (≤ V_ACTIVE−HEIGHT).

Ports:

- `clk` in 1: system clock; one clock, all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `x_px` in 10: current scan x from the sync generator.
- `y_px` in 10: current scan y from the sync generator.
- `enable` in 1: run the animation when high; freeze it when low.
- `x_numbers` out 10: digit box left edge.
- `y_numbers` out 10: digit box top edge.
- `number` out 3: digit index 0..7.
- `frame_tick` out 1: one-cycle pulse marking the start of an update.

## Operation

- **Frame detect.** `sof = (x_px == 0) && (y_px == V_ACTIVE)`.
  - Register it into `sof_q`.
  - The event is the rising edge `sof && !sof_q`.
  - A scan position held for several clk cycles gives exactly one event.
- **FSM states:** IDLE, MOVE_X, MOVE_Y, COUNT.
  - IDLE → MOVE_X on a frame event with `enable` = 1. Otherwise stay in IDLE; events while `enable` = 0 are dropped, not queued.
  - MOVE_X → MOVE_Y → COUNT → IDLE unconditionally, one cycle each.
  - Frame events arriving outside IDLE are ignored.
- **MOVE_X.** Arithmetic is 11-bit unsigned, so there is no wrap.
  - Moving right (`dir_x` = 0):
    - If `x + WIDTH + STEP > H_ACTIVE`: set `x = H_ACTIVE − WIDTH` and `dir_x = 1`.
    - Otherwise: `x = x + STEP`.
  - Moving left (`dir_x` = 1):
    - If `x < STEP`: set `x = 0` and `dir_x = 0`.
    - Otherwise: `x = x − STEP`.
- **MOVE_Y.** Same rules using `y`, `HEIGHT`, `V_ACTIVE` and `dir_y` (0 = down).
- **Corner hit.** Both axes clamp and flip in the same frame, each in its own state. No special case is needed.
- **COUNT.** Frame counter `fcnt` (10 bits):
  - If `fcnt == FRAMES_PER_COUNT − 1`: set `fcnt = 0` and `number = number + 1`, wrapping 7 → 0.
  - Otherwise: `fcnt = fcnt + 1`.
- **Invariants.** `x_numbers` never exceeds H_ACTIVE−WIDTH and `y_numbers` never exceeds V_ACTIVE−HEIGHT.
- **Reset values:**
  - Outputs: `x_numbers = X_INIT`, `y_numbers = Y_INIT`, `number = 0`, `frame_tick = 0`.
  - Internal: `dir_x = dir_y = 0`, `fcnt = 0`, `sof_q = 0`, state IDLE.
- **Reset mid-sequence.** Returns immediately to the reset values. No partial update survives, and the next frame event starts a clean sequence.
- **`enable` falling mid-sequence.** Does not abort the sequence; it completes through COUNT.

## Timing

- Cycle T: the edge that samples the frame event.
- T+1: `frame_tick` = 1 (high for exactly one cycle) and the state is MOVE_X.
- T+2: new `x_numbers` visible.
- T+3: new `y_numbers` visible.
- T+4: new `number` visible; state back to IDLE.
- All outputs are registered and change only in these cycles. They are therefore constant throughout the active region, so the renderer never sees a mid-frame move.
- One update per frame at most; at 60 Hz with the default `FRAMES_PER_COUNT`, the digit advances once per second.

## Test plan

- **Reset:** assert `reset` asynchronously mid-cycle → outputs show 312/230/0 and `frame_tick` = 0 before the next clk edge.
- **Single frame:** `enable` = 1, scan to (0, 480) held for 4 clk cycles →
  - exactly one `frame_tick`;
  - `x_numbers` = 313 at T+2 and `y_numbers` = 231 at T+3;
  - `number` stays 0.
- **Right-wall bounce:** `X_INIT` = 623, `STEP` = 2, one frame →
  - `x_numbers` = 624 (clamped) and `dir_x` flips;
  - the next frame gives `x_numbers` = 622.
- **Corner:** `X_INIT` = 624, `Y_INIT` = 461, `STEP` = 1, one frame →
  - `x_numbers` = 624 and `y_numbers` = 461, both clamped, both directions flip;
  - the next frame gives 623/460.
- **Digit wrap:** `FRAMES_PER_COUNT` = 3, run 24 frames →
  - `number` steps 0→1 after frame 3 and so on, reaching 7 after frame 21;
  - it is 0 after frame 24, each change at T+4 of that frame.
- **Enable low:** run 5 frames with `enable` = 0 → no `frame_tick` and outputs unchanged. Raise `enable` → the next frame moves by exactly one STEP.
- **Reset mid-sequence:** assert `reset` during MOVE_Y → post-reset values as in the reset test; the following frame yields 313/231.
